uart_cmd_ctrl: RTL and testbench

Frame assembler and sequencer sitting directly behind the UART receiver.
- Consumes received bytes through the receiver's rdy/clr_rdy handshake.
- Packs FRAME_BYTES consecutive bytes MSB-first into one command word.
- Presents the word to the command-processing logic with a valid/ack handshake.
- Aborts stale partial frames on an inter-byte timeout.
- Applies backpressure by leaving received bytes unconsumed while a command is pending.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_cmd_timeout.sv | 29 ++
 rtl/uart_cmd_ctrl.sv | 112 +++++++++++
 tb/tb_uart_cmd_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART command path.
package uart_pkg;

    localparam int UART_BYTE_W     = 8;
    localparam int FRAME_BYTES_DEF = 3;
    localparam int TIMEOUT_CYC_DEF = 20000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VALID   = 2'd2
    } uart_ctrl_state_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Saturating inter-byte timer: clr reloads zero, en counts, expired flags the last allowed cycle.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (clr) begin
            timer <= '0;
        end else if (en && (timer != LAST)) begin
            timer <= timer + TW'(1);
        end
    end

    assign expired = (timer == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Packs received UART bytes MSB-first into command words and hands them on with valid/ack.
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [UART_BYTE_W-1:0]           rx_data,
    input  logic                             rx_rdy,
    output logic                             rx_clr_rdy,
    input  logic                             flush,
    output logic [UART_BYTE_W*FRAME_BYTES-1:0] cmd_data,
    output logic                             cmd_valid,
    input  logic                             cmd_ack,
    output logic                             frame_err,
    output logic                             busy,
    output logic [1:0]                       dbg_state
);

    localparam int W     = UART_BYTE_W * FRAME_BYTES;
    localparam int CNT_W = $clog2(FRAME_BYTES + 1);

    uart_ctrl_state_t state, state_nxt;
    logic [CNT_W-1:0] byte_cnt;
    logic [W-1:0]     shift_reg;
    logic [W-1:0]     shifted;
    logic             take;
    logic             last;
    logic             timeout;
    logic             tmr_expired;
    logic             tmr_clr;
    logic             tmr_en;

    // Handshakes: a byte moves when rx_rdy and rx_clr_rdy are both high at an edge;
    // a command moves when cmd_valid and cmd_ack are both high at an edge. Neither
    // side withdraws its offer, and flush cancels both transfers for that cycle.

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            shift_reg <= '0;
            cmd_data  <= '0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_valid <= (state_nxt == VALID);
            frame_err <= timeout;
            if (flush || timeout) begin
                byte_cnt <= '0;
            end else if (take) begin
                byte_cnt <= last ? '0 : byte_cnt + CNT_W'(1);
            end
            if (take) begin
                shift_reg <= shifted;
            end
            if (take && last) begin
                cmd_data <= shifted;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        last      = (byte_cnt == CNT_W'(FRAME_BYTES - 1));
        take      = rx_rdy && !rst && !flush && ((state == IDLE) || (state == COLLECT));
        timeout   = (state == COLLECT) && !take && !flush && tmr_expired;
        // Shift form keeps the single-byte frame legal (no negative slice).
        shifted   = (shift_reg << UART_BYTE_W) | W'(rx_data);
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, COLLECT: begin
                    if (take) begin
                        state_nxt = last ? VALID : COLLECT;
                    end else if (timeout) begin
                        state_nxt = IDLE;
                    end
                end
                VALID: begin
                    if (cmd_ack) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_clr_rdy = take;
        busy       = (state != IDLE);
        dbg_state  = state;
        tmr_clr    = take || flush || timeout || (state != COLLECT);
        tmr_en     = (state == COLLECT);
    end

    uart_cmd_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a small receiver model driving rx_rdy.
module tb_uart_cmd_ctrl;
    import uart_pkg::*;

    localparam int FB  = 3;
    localparam int TMO = 200;

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_rdy;
    logic          rx_clr_rdy;
    logic          flush;
    logic [23:0]   cmd_data;
    logic          cmd_valid;
    logic          cmd_ack;
    logic          frame_err;
    logic          busy;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;
    int clr_cnt  = 0;
    logic clr_seen;

    uart_cmd_ctrl #(
        .FRAME_BYTES (FB),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .rx_clr_rdy (rx_clr_rdy),
        .flush      (flush),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ack    (cmd_ack),
        .frame_err  (frame_err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks; the receiver drops rdy at the edge where it was cleared.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            clr_seen = rx_clr_rdy;
            if (clr_seen) clr_cnt++;
            @(posedge clk);
            #1;
            if (clr_seen) rx_rdy = 1'b0;
        end
    endtask

    task automatic give(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_rdy  = 1'b1;
        flush   = 1'b0;
        cmd_ack = 1'b0;
        #1;
        chk("clr_in_reset", 32'(rx_clr_rdy), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_data", 32'(cmd_data), 32'h0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        step(2);

        // Spaced frame, ack held high
        cmd_ack = 1'b1;
        clr_cnt = 0;
        give(8'hA5);
        #1;
        chk("t1_clr_mealy", 32'(rx_clr_rdy), 32'd1);
        step(1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_state", 32'(dbg_state), 32'(COLLECT));
        step(99);
        give(8'h12);
        step(100);
        give(8'h34);
        #1;
        chk("t1_valid_pre", 32'(cmd_valid), 32'd0);
        step(1);
        chk("t1_valid", 32'(cmd_valid), 32'd1);
        chk("t1_data", 32'(cmd_data), 32'hA51234);
        step(1);
        chk("t1_valid_drop", 32'(cmd_valid), 32'd0);
        chk("t1_busy_drop", 32'(busy), 32'd0);
        chk("t1_clr_pulses", 32'(clr_cnt), 32'd3);

        // Inter-byte timeout, then a clean frame
        give(8'h11);
        step(1);
        give(8'h22);
        step(1);
        step(TMO - 1);
        chk("t2_err_early", 32'(frame_err), 32'd0);
        chk("t2_busy_early", 32'(busy), 32'd1);
        step(1);
        chk("t2_err", 32'(frame_err), 32'd1);
        chk("t2_state", 32'(dbg_state), 32'(IDLE));
        step(1);
        chk("t2_err_pulse", 32'(frame_err), 32'd0);
        give(8'h01);
        step(1);
        give(8'h02);
        step(1);
        give(8'h03);
        step(1);
        chk("t2_valid", 32'(cmd_valid), 32'd1);
        chk("t2_data", 32'(cmd_data), 32'h010203);
        step(1);

        // Backpressure while a command is pending
        cmd_ack = 1'b0;
        give(8'hDE);
        step(1);
        give(8'hAD);
        step(1);
        give(8'hBE);
        step(1);
        chk("t3_valid", 32'(cmd_valid), 32'd1);
        give(8'h77);
        #1;
        chk("t3_clr_blocked", 32'(rx_clr_rdy), 32'd0);
        step(5);
        chk("t3_clr_still", 32'(rx_clr_rdy), 32'd0);
        chk("t3_data_hold", 32'(cmd_data), 32'hDEADBE);
        chk("t3_valid_hold", 32'(cmd_valid), 32'd1);
        cmd_ack = 1'b1;
        #1;
        chk("t3_clr_ack_cycle", 32'(rx_clr_rdy), 32'd0);
        step(1);
        chk("t3_valid_acked", 32'(cmd_valid), 32'd0);
        chk("t3_clr_idle", 32'(rx_clr_rdy), 32'd1);
        step(1);
        chk("t3_state_collect", 32'(dbg_state), 32'(COLLECT));
        give(8'h88);
        step(1);
        give(8'h99);
        step(1);
        chk("t3_valid2", 32'(cmd_valid), 32'd1);
        chk("t3_data2", 32'(cmd_data), 32'h778899);
        step(1);

        // Last byte lands in the timeout cycle
        give(8'hC1);
        step(1);
        give(8'hC2);
        step(1);
        step(TMO - 1);
        give(8'hC3);
        step(1);
        chk("t4_valid", 32'(cmd_valid), 32'd1);
        chk("t4_err", 32'(frame_err), 32'd0);
        chk("t4_data", 32'(cmd_data), 32'hC1C2C3);
        step(1);
        chk("t4_err_after", 32'(frame_err), 32'd0);

        // Flush in COLLECT and in VALID
        give(8'hF1);
        step(1);
        chk("t5_busy_collect", 32'(busy), 32'd1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("t5_busy_flush", 32'(busy), 32'd0);
        chk("t5_err_flush", 32'(frame_err), 32'd0);
        cmd_ack = 1'b0;
        give(8'h0A);
        step(1);
        give(8'h0B);
        step(1);
        give(8'h0C);
        step(1);
        chk("t5_valid", 32'(cmd_valid), 32'd1);
        flush   = 1'b1;
        cmd_ack = 1'b1;
        step(1);
        chk("t5_valid_flush", 32'(cmd_valid), 32'd0);
        chk("t5_busy_vflush", 32'(busy), 32'd0);
        chk("t5_data_kept", 32'(cmd_data), 32'h0A0B0C);
        give(8'hE0);
        #1;
        chk("t5_clr_flush", 32'(rx_clr_rdy), 32'd0);
        flush = 1'b0;
        step(1);
        give(8'hE1);
        step(1);
        give(8'hE2);
        step(1);
        chk("t5_data_next", 32'(cmd_data), 32'hE0E1E2);
        chk("t5_valid_next", 32'(cmd_valid), 32'd1);
        step(1);

        // Asynchronous reset mid-frame
        give(8'h55);
        step(1);
        give(8'h66);
        step(1);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_data_rst", 32'(cmd_data), 32'h0);
        chk("t6_valid_rst", 32'(cmd_valid), 32'd0);
        chk("t6_clr_rst", 32'(rx_clr_rdy), 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        give(8'h21);
        step(1);
        give(8'h43);
        step(1);
        give(8'h65);
        step(1);
        chk("t6_valid", 32'(cmd_valid), 32'd1);
        chk("t6_data", 32'(cmd_data), 32'h214365);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
